// File: rtl/matrix_printer.sv
// rtl/matrix_printer.sv - BRAM matrix to decimal ASCII UART printer (header line enabled by MATRIX_PRINT_HEADER_EN)

`ifndef ELEMENT_WIDTH
`define ELEMENT_WIDTH 8
`endif
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 10
`endif
`ifndef ERR_NONE
`define ERR_NONE 4'h0
`endif
`ifndef ERR_DIM_RANGE
`define ERR_DIM_RANGE 4'h1
`endif

module matrix_printer #(
    parameter int ELEMENT_WIDTH = `ELEMENT_WIDTH,
    parameter int ADDR_WIDTH    = `BRAM_ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode_active,
    input  logic                     start,
    input  logic [3:0]               mat_m,
    input  logic [3:0]               mat_n,
    input  logic [ADDR_WIDTH-1:0]    mat_addr,
    input  logic [3:0]               config_max_dim,
    output logic                     mem_rd_en,
    output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
    input  logic [ELEMENT_WIDTH-1:0] mem_rd_data,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic                     busy,
    output logic                     done,
    output logic [3:0]               error_code
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] CHECK    = 4'd1;
    localparam logic [3:0] HDR      = 4'd2;
    localparam logic [3:0] RD_REQ   = 4'd3;
    localparam logic [3:0] RD_WAIT  = 4'd4;
    localparam logic [3:0] CONVERT  = 4'd5;
    localparam logic [3:0] SEND     = 4'd6;
    localparam logic [3:0] TX_GUARD = 4'd7;
    localparam logic [3:0] TX_WAIT  = 4'd8;
    localparam logic [3:0] DONE     = 4'd9;
    localparam logic [3:0] ERROR    = 4'd10;

    logic [3:0]            state_q, state_d;
    logic [3:0]            m_q, m_d;
    logic [3:0]            n_q, n_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [7:0]            elem_q, elem_d;
    logic [3:0]            col_q, col_d;
    logic [3:0]            row_q, row_d;
    logic [7:0]            val_q, val_d;
    logic [39:0]           buf_q, buf_d;
    logic [2:0]            len_q, len_d;
    logic [2:0]            idx_q, idx_d;
    logic                  hdr_phase_q, hdr_phase_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_start_q, tx_start_d;
    logic                  done_q, done_d;
    logic [3:0]            err_q, err_d;

    logic [7:0]            rem;
    logic [3:0]            hund, tens, ones;
    logic [39:0]           conv_buf;
    logic [2:0]            conv_len;
    logic                  last_col;
    logic [7:0]            cur_byte;

    // Element index is walked linearly, so base + index equals base + row*n + col.
    assign mem_rd_addr = base_q + ADDR_WIDTH'(elem_q);
    assign mem_rd_en   = (state_q == RD_REQ);
    assign busy        = (state_q != IDLE) && (state_q != ERROR);
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign done        = done_q;
    assign error_code  = err_q;
    assign last_col    = (col_q == n_q - 4'd1);
    assign cur_byte    = buf_q[8*idx_q +: 8];

    // Compare-subtract decimal split and per-element byte string (digits + separator).
    always_comb begin
        rem  = val_q;
        hund = 4'd0;
        tens = 4'd0;
        if (rem >= 8'd200) begin
            hund = 4'd2;
            rem  = rem - 8'd200;
        end else if (rem >= 8'd100) begin
            hund = 4'd1;
            rem  = rem - 8'd100;
        end
        for (int k = 0; k < 9; k++) begin
            if (rem >= 8'd10) begin
                rem  = rem - 8'd10;
                tens = tens + 4'd1;
            end
        end
        ones = 4'(rem);

        conv_buf = '0;
        conv_len = 3'd0;
        if (hund != 4'd0) begin
            conv_buf[8*conv_len +: 8] = 8'h30 + {4'h0, hund};
            conv_len = conv_len + 3'd1;
        end
        if ((hund != 4'd0) || (tens != 4'd0)) begin
            conv_buf[8*conv_len +: 8] = 8'h30 + {4'h0, tens};
            conv_len = conv_len + 3'd1;
        end
        conv_buf[8*conv_len +: 8] = 8'h30 + {4'h0, ones};
        conv_len = conv_len + 3'd1;
        if (last_col) begin
            conv_buf[8*conv_len +: 8] = 8'h0D;
            conv_len = conv_len + 3'd1;
            conv_buf[8*conv_len +: 8] = 8'h0A;
            conv_len = conv_len + 3'd1;
        end else begin
            conv_buf[8*conv_len +: 8] = 8'h20;
            conv_len = conv_len + 3'd1;
        end
    end

    // Next-state logic; mode_active low overrides every state.
    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        n_d         = n_q;
        base_d      = base_q;
        elem_d      = elem_q;
        col_d       = col_q;
        row_d       = row_q;
        val_d       = val_q;
        buf_d       = buf_q;
        len_d       = len_q;
        idx_d       = idx_q;
        hdr_phase_d = hdr_phase_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        done_d      = 1'b0;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d         = mat_m;
                    n_d         = mat_n;
                    base_d      = mat_addr;
                    elem_d      = 8'd0;
                    col_d       = 4'd0;
                    row_d       = 4'd0;
                    hdr_phase_d = 1'b0;
                    err_d       = `ERR_NONE;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if ((m_q == 4'd0) || (n_q == 4'd0) ||
                    (m_q > config_max_dim) || (n_q > config_max_dim)) begin
                    err_d   = `ERR_DIM_RANGE;
                    done_d  = 1'b1;
                    state_d = ERROR;
                end else begin
`ifdef MATRIX_PRINT_HEADER_EN
                    state_d = HDR;
`else
                    state_d = RD_REQ;
`endif
                end
            end
            HDR: begin
`ifdef MATRIX_PRINT_HEADER_EN
                buf_d       = {8'h0A, 8'h0D, 8'h30 + {4'h0, n_q}, 8'h20, 8'h30 + {4'h0, m_q}};
                len_d       = 3'd5;
                idx_d       = 3'd0;
                hdr_phase_d = 1'b1;
                state_d     = SEND;
`else
                state_d     = RD_REQ;
`endif
            end
            RD_REQ: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                val_d   = 8'(mem_rd_data);
                state_d = CONVERT;
            end
            CONVERT: begin
                buf_d   = conv_buf;
                len_d   = conv_len;
                idx_d   = 3'd0;
                state_d = SEND;
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_data_d  = cur_byte;
                    tx_start_d = 1'b1;
                    state_d    = TX_GUARD;
                end
            end
            TX_GUARD: begin
                // The UART may not have raised busy yet, so this cycle ignores it.
                state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (!tx_busy) begin
                    if (idx_q + 3'd1 != len_q) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = SEND;
                    end else if (hdr_phase_q) begin
                        hdr_phase_d = 1'b0;
                        state_d     = RD_REQ;
                    end else if ((row_q == m_q - 4'd1) && last_col) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        elem_d = elem_q + 8'd1;
                        if (last_col) begin
                            col_d = 4'd0;
                            row_d = row_q + 4'd1;
                        end else begin
                            col_d = col_q + 4'd1;
                        end
                        state_d = RD_REQ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!mode_active) begin
            state_d    = IDLE;
            tx_start_d = 1'b0;
            done_d     = 1'b0;
            err_d      = `ERR_NONE;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            m_q         <= 4'd0;
            n_q         <= 4'd0;
            base_q      <= '0;
            elem_q      <= 8'd0;
            col_q       <= 4'd0;
            row_q       <= 4'd0;
            val_q       <= 8'd0;
            buf_q       <= '0;
            len_q       <= 3'd0;
            idx_q       <= 3'd0;
            hdr_phase_q <= 1'b0;
            tx_data_q   <= 8'd0;
            tx_start_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= `ERR_NONE;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            n_q         <= n_d;
            base_q      <= base_d;
            elem_q      <= elem_d;
            col_q       <= col_d;
            row_q       <= row_d;
            val_q       <= val_d;
            buf_q       <= buf_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            hdr_phase_q <= hdr_phase_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: doc/matrix_printer.md
MATRIX_PRINTER -- requirements
Module: matrix_printer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ELEMENT_WIDTH, `ELEMENT_WIDTH (8), stored element width, unsigned.
- ADDR_WIDTH, `BRAM_ADDR_WIDTH, matrix BRAM address width.
REQ-002 The block SHALL have these ports (name direction width meaning):
- clk in 1: clock.
- rst_n in 1: reset, asynchronous, active-low.
- mode_active in 1: enable; low aborts to IDLE.
- start in 1: one-cycle print request.
- mat_m, mat_n in 4: rows and columns of the matrix to print.
- mat_addr in ADDR_WIDTH: base address, row-major layout.
- config_max_dim in 4: maximum legal dimension.
- mem_rd_en out 1: BRAM read strobe.
- mem_rd_addr out ADDR_WIDTH: BRAM read address.
- mem_rd_data in ELEMENT_WIDTH: BRAM read data, valid exactly 1 cycle after mem_rd_en.
- tx_data out 8: UART byte.
- tx_start out 1: one-cycle UART send pulse.
- tx_busy in 1: UART transmitter busy.
- busy out 1: print in progress.
- done out 1: one-cycle completion pulse.
- error_code out 4: `ERR_* code from matrix_pkg.vh.

Function
REQ-003 States SHALL be IDLE, CHECK, HDR, RD_REQ, RD_WAIT, CONVERT, SEND, TX_GUARD, TX_WAIT, DONE, ERROR.
REQ-004 IDLE SHALL latch mat_m, mat_n and mat_addr when start=1, clear error_code to `ERR_NONE`, and go to CHECK; start SHALL be ignored in every other state.
REQ-005 In CHECK, if m=0, n=0, m>config_max_dim or n>config_max_dim, the block SHALL set error_code=`ERR_DIM_RANGE` and go to ERROR; otherwise it SHALL go to HDR (macro on) or RD_REQ (macro off).
REQ-006 RD_REQ SHALL pulse mem_rd_en for 1 cycle with mem_rd_addr = base + row*n + col, using an incrementing element index and no multiplier; RD_WAIT SHALL capture mem_rd_data on the following cycle.
REQ-007 CONVERT SHALL split the value into hundreds/tens/ones ASCII digits using compare-subtract, with no divider.
- Leading zeros SHALL be suppressed.
- Value 0 SHALL print as "0"; 255 SHALL print as "255".
REQ-008 The byte sequence per element SHALL be its digits, then a separator.
- Separator is " " (0x20) if col<n-1.
- Otherwise it is "\r\n" (0x0D 0x0A) at the end of each row.
REQ-009 Every byte SHALL use this handshake:
- Wait until tx_busy=0.
- Drive tx_data and pulse tx_start for exactly 1 cycle.
- Spend 1 TX_GUARD cycle ignoring tx_busy.
- In TX_WAIT, wait for tx_busy=0 before the next byte.
REQ-010 After the last element's "\r\n", the block SHALL pulse done for 1 cycle in DONE, then return to IDLE.
REQ-011 busy SHALL be 1 in every state except IDLE and ERROR.
REQ-012 ERROR SHALL hold error_code, keep tx_start=0 and mem_rd_en=0, pulse done once on entry, and then stay until mode_active=0 or reset.
REQ-013 mode_active=0 in any state SHALL force IDLE on the next edge, deassert tx_start, mem_rd_en, done and busy, and clear error_code to `ERR_NONE`; a byte already handed to the UART is not recalled.
REQ-014 Element and column counters SHALL be 8-bit and 4-bit with no wrap; the maximum is m*n=225 with 4-bit dimensions.

Reset
REQ-015 While rst_n=0, the block SHALL force state=IDLE and set every output to 0, with error_code=`ERR_NONE`, mem_rd_addr=0, tx_data=0, and all counters and latches=0.
REQ-016 Reset asserted mid-print SHALL abort immediately, and no further UART or BRAM activity SHALL occur after reset is released until a new start.

Configuration
REQ-017 Macro MATRIX_PRINT_HEADER_EN SHALL control the header.
- Defined: HDR SHALL send ASCII m, " ", ASCII n, "\r\n" (5 bytes, same handshake) before the first element.
- Undefined: HDR SHALL be unreachable and printing SHALL begin with element 0.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- 2x3 at addr 0x10 holding 1,2,3,4,5,6, macro off -> bytes "1 2 3\r\n4 5 6\r\n", reads at 0x10..0x15 in order, one done pulse.
- 1x3 holding 0,10,255 -> "0 10 255\r\n".
- m=0 or m=6 with config_max_dim=5 -> error_code=`ERR_DIM_RANGE`, no tx_start, done once.
- tx_busy held high 50 cycles after each tx_start -> no byte lost or duplicated, tx_start never asserted while tx_busy=1.
- mode_active dropped during the 2nd element, then a new start -> IDLE next cycle, busy=0, and the new print completes correctly.
- Macro on, 2x2 holding 7,8,9,1 -> "2 2\r\n7 8\r\n9 1\r\n".
